symbol_histogram_collector: RTL and testbench
=============================================

Name: symbol_histogram_collector

Overview:
- Downstream stage of the symbol counter; runs in that counter's read-out phase (end_flag=1).
- Repeatedly requests one (symbol, count) record over the start/ready handshake.
- Stores each record in an internal table, accumulates the total, tracks the most frequent symbol, and stops on the 0x00 terminator symbol.
- Results are exposed on a random-access read port and summary outputs for the display/UART logic.

Parameters:
- DEPTH, 28, table entries; equals the alphabet size including 0x00.
- SYM_W, 8, symbol width.
- CNT_W, 8, per-symbol count width.
- SUM_W, 16, total accumulator width.
- TIMEOUT, 255, max cycles waited for a ready rising edge before abort.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- collect  in  1  one-cycle pulse; starts a collection run; ignored unless in IDLE or DONE.
- cnt_ready  in  1  counter ready_out; record valid on its rising edge.
- cnt_symbol  in  SYM_W  counter symbol_out.
- cnt_count  in  CNT_W  counter count_array.
- cnt_start  out  1  counter start request.
- rd_addr  in  clog2(DEPTH)  table read index.
- rd_symbol  out  SYM_W  symbol at rd_addr; registered, 1-cycle latency.
- rd_count  out  CNT_W  count at rd_addr; registered, 1-cycle latency.
- entries  out  clog2(DEPTH)+1  number of valid stored records.
- total  out  SUM_W  sum of stored counts.
- max_symbol  out  SYM_W  symbol with the highest count.
- max_count  out  CNT_W  highest count.
- busy  out  1  high in REQ/WAIT/GAP.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a non-terminator record was dropped because the table was full.
- timeout  out  1  sticky; the run aborted waiting for ready.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; cnt_start=0; all outputs 0; table contents 0; ready_q=0.
- Ready edge detection:
  - ready_q registers cnt_ready.
  - rise = cnt_ready & ~ready_q.
  - A level held high produces exactly one rise.
- States:
  - IDLE: on collect, clear entries, total, max_*, overflow and timeout; go to REQ.
  - REQ: drive cnt_start=1; clear the wait counter; go to WAIT next cycle.
  - WAIT:
    - cnt_start stays 1; the wait counter increments each cycle.
    - On rise, capture cnt_symbol/cnt_count in the same edge and go to STORE.
    - If the wait counter reaches TIMEOUT with no rise, set timeout and go to DONE.
  - STORE: cnt_start=0.
    - Terminator: if the captured symbol is 0x00, do not store or sum it; go to DONE.
    - Table has space (entries<DEPTH): write table[entries]; entries+1; total+=count, saturating at 2^SUM_W-1; if count>max_count (strictly greater), update max_symbol/max_count. Go to GAP.
    - Table full: drop the record; set overflow; go to GAP.
  - GAP: cnt_start=0 for exactly 2 cycles, meeting the counter's minimum start-low time; then go to REQ.
  - DONE: done=1; results held; collect restarts the run (same clearing as IDLE).
- Tie on max count: the first-received symbol is kept. If all counts are 0, max_symbol=0 and max_count=0.
- collect while busy: ignored.
- rise outside WAIT: ignored; no capture.
- Read port: always active. rd_addr>=entries returns 0/0. A write and a read to the same address in one cycle return the old value.
- Reset mid-run: immediate return to IDLE; cnt_start drops asynchronously.

Test Plan:
1. Three records ('a',5), ('b',9), ('c',9), then (0x00,0) -> entries=3, total=23, max_symbol='b', max_count=9, done=1; rd_addr=1 next cycle gives 'b'/9.
2. Handshake timing: ready rises 4 cycles after cnt_start -> capture on that edge; cnt_start low exactly 3 cycles (STORE+GAP), then high again; a ready held high 10 cycles yields one record.
3. Overflow: 30 non-zero records with count 1, then terminator -> entries=28, total=28, overflow=1, done=1.
4. Saturation: DEPTH=28 records all count 255 with SUM_W=12 -> total=4095.
5. Timeout: no ready after REQ -> after 255 WAIT cycles, timeout=1, done=1, cnt_start=0, entries unchanged.
6. Reset asserted in WAIT with cnt_start=1 -> cnt_start=0 without waiting for a clock edge; all outputs 0; after release, a collect pulse restarts cleanly.

Source files
------------

// File: rtl/symbol_histogram_collector.sv
// symbol_histogram_collector: pulls (symbol, count) records from the symbol counter into a table with total and max tracking
module symbol_histogram_collector #(
  parameter int DEPTH   = 28,
  parameter int SYM_W   = 8,
  parameter int CNT_W   = 8,
  parameter int SUM_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      collect,
  input  logic                      cnt_ready,
  input  logic [SYM_W-1:0]          cnt_symbol,
  input  logic [CNT_W-1:0]          cnt_count,
  output logic                      cnt_start,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr,
  output logic [SYM_W-1:0]          rd_symbol,
  output logic [CNT_W-1:0]          rd_count,
  output logic [$clog2(DEPTH):0]    entries,
  output logic [SUM_W-1:0]          total,
  output logic [SYM_W-1:0]          max_symbol,
  output logic [CNT_W-1:0]          max_count,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, STORE, GAP, DONE} state_t;
  state_t state, state_nx;
  logic ready_q, rise, start_run, gap_cnt, wait_end, has_space;
  logic [WW-1:0] wait_cnt;
  logic [SYM_W-1:0] cap_sym;
  logic [CNT_W-1:0] cap_cnt;
  logic [SUM_W:0] sum_ext;
  logic [SYM_W-1:0] sym_mem [DEPTH];
  logic [CNT_W-1:0] cnt_mem [DEPTH];
  assign rise      = cnt_ready & ~ready_q;
  assign start_run = collect && (state == IDLE || state == DONE);
  assign wait_end  = wait_cnt == WW'(TIMEOUT - 1);
  assign has_space = entries < (AW+1)'(DEPTH);
  assign sum_ext   = {1'b0, total} + (SUM_W+1)'(cap_cnt);
  assign cnt_start = state == REQ || state == WAIT;
  assign busy      = state == REQ || state == WAIT || state == GAP;
  assign done      = state == DONE;
  // state register; async reset drops cnt_start immediately
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next-state logic for the request/wait/store/gap loop
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = collect ? REQ : state;
      REQ:        state_nx = WAIT;
      WAIT:       state_nx = rise ? STORE : (wait_end ? DONE : WAIT);
      STORE:      state_nx = cap_sym == '0 ? DONE : GAP;
      GAP:        state_nx = gap_cnt ? REQ : GAP;
      default:    state_nx = IDLE;
    endcase
  end
  // capture, table write, statistics and registered read port
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ready_q    <= 1'b0;
      gap_cnt    <= 1'b0;
      wait_cnt   <= '0;
      cap_sym    <= '0;
      cap_cnt    <= '0;
      entries    <= '0;
      total      <= '0;
      max_symbol <= '0;
      max_count  <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      rd_symbol  <= '0;
      rd_count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sym_mem[i] <= '0;
        cnt_mem[i] <= '0;
      end
    end else begin
      ready_q   <= cnt_ready;
      gap_cnt   <= state == GAP ? ~gap_cnt : 1'b0;
      rd_symbol <= {1'b0, rd_addr} < entries ? sym_mem[rd_addr] : '0;
      rd_count  <= {1'b0, rd_addr} < entries ? cnt_mem[rd_addr] : '0;
      if (start_run) begin
        entries    <= '0;
        total      <= '0;
        max_symbol <= '0;
        max_count  <= '0;
        overflow   <= 1'b0;
        timeout    <= 1'b0;
      end
      if (state == REQ) wait_cnt <= '0;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (rise) begin
          cap_sym <= cnt_symbol;
          cap_cnt <= cnt_count;
        end else if (wait_end) timeout <= 1'b1;
      end
      if (state == STORE && cap_sym != '0) begin
        if (has_space) begin
          sym_mem[entries[AW-1:0]] <= cap_sym;
          cnt_mem[entries[AW-1:0]] <= cap_cnt;
          entries <= entries + 1'b1;
          total   <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
          if (cap_cnt > max_count) begin
            max_symbol <= cap_sym;
            max_count  <= cap_cnt;
          end
        end else overflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_symbol_histogram_collector.sv
// tb_symbol_histogram_collector: directed checks of collection, handshake timing, overflow, saturation, timeout and reset
module tb_symbol_histogram_collector;
  logic clock = 1'b0, reset = 1'b0, collect = 1'b0, cnt_ready = 1'b0;
  logic [7:0] cnt_symbol = '0, cnt_count = '0;
  logic cnt_start, busy, done, overflow, timeout;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_symbol, rd_count, max_symbol, max_count;
  logic [5:0] entries;
  logic [11:0] total;
  int vectors = 0, miscompares = 0;

  symbol_histogram_collector #(.DEPTH(28), .SYM_W(8), .CNT_W(8), .SUM_W(12), .TIMEOUT(255)) dut (
    .clock(clock), .reset(reset), .collect(collect), .cnt_ready(cnt_ready),
    .cnt_symbol(cnt_symbol), .cnt_count(cnt_count), .cnt_start(cnt_start),
    .rd_addr(rd_addr), .rd_symbol(rd_symbol), .rd_count(rd_count),
    .entries(entries), .total(total), .max_symbol(max_symbol), .max_count(max_count),
    .busy(busy), .done(done), .overflow(overflow), .timeout(timeout));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_collect();
    tick();
    collect = 1'b1;
    tick();
    collect = 1'b0;
  endtask

  // counter model: wait for start, then present a record dly cycles later, held for hold edges
  task automatic serve(input logic [7:0] sym, input logic [7:0] cnt, input int dly, input int hold);
    int t = 0;
    while (!cnt_start && t < 1000) begin
      tick();
      t++;
    end
    if (t >= 1000) chk("start_wait", 32'(cnt_start), 1);
    repeat (dly) tick();
    cnt_symbol = sym;
    cnt_count  = cnt;
    cnt_ready  = 1'b1;
    repeat (hold) tick();
    cnt_ready = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done && t < budget) begin
      tick();
      t++;
    end
    chk("done_reached", 32'(done), 1);
  endtask

  task automatic read_at(input logic [4:0] a);
    rd_addr = a;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int low;
    #12;
    chk("rst_start", 32'(cnt_start), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_entries", 32'(entries), 0);
    chk("rst_total", 32'(total), 0);
    reset = 1'b1;
    // basic collection with a tie on the maximum
    pulse_collect();
    chk("busy_run", 32'(busy), 1);
    serve(8'h61, 8'd5, 1, 1);
    serve(8'h62, 8'd9, 1, 1);
    serve(8'h63, 8'd9, 1, 1);
    serve(8'h00, 8'd0, 1, 1);
    wait_done(50);
    chk("t1_entries", 32'(entries), 3);
    chk("t1_total", 32'(total), 23);
    chk("t1_max_sym", 32'(max_symbol), 32'h62);
    chk("t1_max_cnt", 32'(max_count), 9);
    chk("t1_busy", 32'(busy), 0);
    read_at(5'd1);
    chk("t1_rd_sym", 32'(rd_symbol), 32'h62);
    chk("t1_rd_cnt", 32'(rd_count), 9);
    read_at(5'd3);
    chk("t1_rd_oob_sym", 32'(rd_symbol), 0);
    chk("t1_rd_oob_cnt", 32'(rd_count), 0);
    // handshake timing with a long ready level
    pulse_collect();
    repeat (4) tick();
    cnt_symbol = 8'h78;
    cnt_count  = 8'd7;
    cnt_ready  = 1'b1;
    tick();
    chk("t2_cap_edge", 32'(cnt_start), 0);
    low = 1;
    while (!cnt_start && low < 20) begin
      tick();
      if (!cnt_start) low++;
    end
    chk("t2_low_cycles", low, 3);
    repeat (6) tick();
    cnt_ready = 1'b0;
    serve(8'h00, 8'd0, 1, 1);
    wait_done(50);
    chk("t2_entries", 32'(entries), 1);
    chk("t2_total", 32'(total), 7);
    // overflow: 30 records into a 28-entry table
    pulse_collect();
    for (int i = 0; i < 30; i++) serve(8'(i + 1), 8'd1, 1, 1);
    serve(8'h00, 8'd0, 1, 1);
    wait_done(50);
    chk("t3_entries", 32'(entries), 28);
    chk("t3_total", 32'(total), 28);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_max_sym", 32'(max_symbol), 1);
    read_at(5'd27);
    chk("t3_rd_last", 32'(rd_symbol), 28);
    // saturation of the 12-bit total
    pulse_collect();
    chk("t3_ovf_cleared", 32'(overflow), 0);
    for (int i = 0; i < 28; i++) serve(8'(i + 1), 8'd255, 1, 1);
    serve(8'h00, 8'd0, 1, 1);
    wait_done(50);
    chk("t4_total_sat", 32'(total), 4095);
    chk("t4_overflow", 32'(overflow), 0);
    chk("t4_max_cnt", 32'(max_count), 255);
    // timeout after two records
    pulse_collect();
    serve(8'h41, 8'd2, 1, 1);
    serve(8'h42, 8'd3, 1, 1);
    repeat (200) tick();
    chk("t5_not_yet", 32'(done), 0);
    chk("t5_waiting", 32'(cnt_start), 1);
    wait_done(150);
    chk("t5_timeout", 32'(timeout), 1);
    chk("t5_start_low", 32'(cnt_start), 0);
    chk("t5_entries", 32'(entries), 2);
    chk("t5_total", 32'(total), 5);
    // asynchronous reset while waiting for ready
    pulse_collect();
    serve(8'h51, 8'd4, 1, 1);
    while (!cnt_start) tick();
    tick();
    chk("t6_in_wait", 32'(cnt_start), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_start_async", 32'(cnt_start), 0);
    chk("t6_entries", 32'(entries), 0);
    chk("t6_total", 32'(total), 0);
    chk("t6_max_cnt", 32'(max_count), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_timeout", 32'(timeout), 0);
    tick();
    reset = 1'b1;
    pulse_collect();
    serve(8'h7a, 8'd3, 1, 1);
    serve(8'h00, 8'd0, 1, 1);
    wait_done(50);
    chk("t6_re_entries", 32'(entries), 1);
    chk("t6_re_total", 32'(total), 3);
    chk("t6_re_max_sym", 32'(max_symbol), 32'h7a);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
